// File: rtl/vsc_pkg.sv
// Shared definitions for the vector sweep checker: FSM state encoding and
// the settle counter width.
package vsc_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_COMPARE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    // Wide enough for the largest settle reload value (SETTLE-1 <= 254).
    localparam int CNT_W = $clog2(256);

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times the settle window of each vector: load has
// priority over decrement, zero flags an expired window.
module settle_timer
    import vsc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustively drives every input vector to two circuits, compares their
// outputs after a settle window and reports equivalence or a counterexample.
module vector_sweep_checker
    import vsc_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 1,
    parameter int SETTLE     = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_OUT-1:0]  impl_y,
    input  logic [N_OUT-1:0]  spec_y,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              equiv,
    output logic              cex_valid,
    output logic [N_IN-1:0]   cex,
    output logic [N_IN:0]     mismatch_cnt
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    state_t          state, state_nx;
    logic            tmr_load, tmr_dec, tmr_zero;
    logic            clear, advance, mismatch;
    logic [N_IN:0]   cnt_nx;

    settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        clear    = 1'b0;
        advance  = 1'b0;
        mismatch = (state == S_COMPARE) && (impl_y != spec_y);
        case (state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    state_nx = S_SETTLE;
                    tmr_load = 1'b1;
                    clear    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_nx = S_COMPARE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_COMPARE: begin
                // The all-ones vector is the last one, so the sweep never wraps.
                if ((&vec) || (mismatch && EARLY_EXIT != 0)) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_SETTLE;
                    tmr_load = 1'b1;
                    advance  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (clear) begin
            cnt_nx = '0;
        end else if (mismatch) begin
            cnt_nx = mismatch_cnt + (N_IN+1)'(1);
        end else begin
            cnt_nx = mismatch_cnt;
        end
    end

    // Status flags are computed from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            equiv        <= 1'b0;
            cex_valid    <= 1'b0;
            cex          <= '0;
            mismatch_cnt <= '0;
        end else begin
            if (clear) begin
                vec       <= '0;
                cex       <= '0;
                cex_valid <= 1'b0;
            end else begin
                if (advance) begin
                    vec <= vec + N_IN'(1);
                end
                if (mismatch && !cex_valid) begin
                    cex       <= vec;
                    cex_valid <= 1'b1;
                end
            end
            mismatch_cnt <= cnt_nx;
            busy         <= (state_nx == S_SETTLE) || (state_nx == S_COMPARE);
            done         <= (state_nx == S_FINISH);
            equiv        <= (state_nx == S_FINISH) && (cnt_nx == '0);
        end
    end

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench: three checker instances (defaults, early exit, long settle)
// compare IMPL = NOT(NAND) against SPEC = AND or OR.
module tb_vector_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] spec_or = 3'b010;
    logic [2:0] busy, done, equiv, cex_valid;
    logic [1:0] vec [3];
    logic [1:0] cex [3];
    logic [2:0] cnt [3];
    logic       impl_y [3];
    logic       spec_y [3];
    logic [1:0] vec_trace [0:63];

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_edge;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_circ
        assign impl_y[g] = ~(~(vec[g][1] & vec[g][0]));
        assign spec_y[g] = spec_or[g] ? (vec[g][1] | vec[g][0]) : (vec[g][1] & vec[g][0]);
    end

    vector_sweep_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .impl_y(impl_y[0]), .spec_y(spec_y[0]), .vec(vec[0]),
        .busy(busy[0]), .done(done[0]), .equiv(equiv[0]),
        .cex_valid(cex_valid[0]), .cex(cex[0]), .mismatch_cnt(cnt[0])
    );

    vector_sweep_checker #(.EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .impl_y(impl_y[1]), .spec_y(spec_y[1]), .vec(vec[1]),
        .busy(busy[1]), .done(done[1]), .equiv(equiv[1]),
        .cex_valid(cex_valid[1]), .cex(cex[1]), .mismatch_cnt(cnt[1])
    );

    vector_sweep_checker #(.SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .impl_y(impl_y[2]), .spec_y(spec_y[2]), .vec(vec[2]),
        .busy(busy[2]), .done(done[2]), .equiv(equiv[2]),
        .cex_valid(cex_valid[2]), .cex(cex[2]), .mismatch_cnt(cnt[2])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulses start for one edge (edge 0), optionally re-pulses it at glitch_edge,
    // and returns the first edge after which done is seen (-1 on timeout).
    task automatic apply_stimulus(input int d, input int max_edges, input int glitch_edge,
                                  output int first_done);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        vec_trace[0] = vec[d];
        check_output("start_clears_cnt", 32'(cnt[d]), 0);
        check_output("start_clears_cexv", 32'(cex_valid[d]), 0);
        check_output("start_busy", 32'(busy[d]), 1);
        check_output("start_done_low", 32'(done[d]), 0);
        first_done = -1;
        for (int k = 1; k <= max_edges; k++) begin
            @(posedge clk);
            #1;
            vec_trace[k] = vec[d];
            start[d] = (k == glitch_edge);
            if (done[d]) begin
                first_done = k;
                break;
            end
        end
        start[d] = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        check_output("reset_vec", 32'(vec[0]), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("idle_after_reset", 32'(busy[0]), 0);

        $display("[TB] equivalent sweep, default parameters");
        apply_stimulus(0, 40, 0, done_edge);
        check_output("eq_done_edge", done_edge, 8);
        check_output("eq_equiv", 32'(equiv[0]), 1);
        check_output("eq_cnt", 32'(cnt[0]), 0);
        check_output("eq_cexv", 32'(cex_valid[0]), 0);
        check_output("eq_vec_hold", 32'(vec[0]), 3);
        check_output("eq_busy_low", 32'(busy[0]), 0);

        $display("[TB] start pulsed while busy");
        apply_stimulus(0, 40, 3, done_edge);
        check_output("glitch_done_edge", done_edge, 8);
        check_output("glitch_equiv", 32'(equiv[0]), 1);

        $display("[TB] non-equivalent sweep AND vs OR");
        spec_or[0] = 1'b1;
        apply_stimulus(0, 40, 0, done_edge);
        check_output("neq_done_edge", done_edge, 8);
        check_output("neq_cnt", 32'(cnt[0]), 2);
        check_output("neq_cex", 32'(cex[0]), 1);
        check_output("neq_cexv", 32'(cex_valid[0]), 1);
        check_output("neq_equiv", 32'(equiv[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        check_output("finish_hold_cnt", 32'(cnt[0]), 2);
        check_output("finish_hold_done", 32'(done[0]), 1);

        $display("[TB] rerun from finish");
        apply_stimulus(0, 40, 0, done_edge);
        check_output("rerun_done_edge", done_edge, 8);
        check_output("rerun_cnt", 32'(cnt[0]), 2);

        $display("[TB] reset in the middle of a sweep");
        spec_or[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("pre_reset_vec", 32'(vec[0]), 2);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_vec", 32'(vec[0]), 0);
        check_output("async_rst_busy", 32'(busy[0]), 0);
        check_output("async_rst_cnt", 32'(cnt[0]), 0);
        check_output("async_rst_done", 32'(done[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("post_reset_idle", 32'(busy[0]), 0);
        apply_stimulus(0, 40, 0, done_edge);
        check_output("post_reset_done_edge", done_edge, 8);
        check_output("post_reset_equiv", 32'(equiv[0]), 1);

        $display("[TB] early exit on first mismatch");
        apply_stimulus(1, 40, 0, done_edge);
        check_output("ee_done_edge", done_edge, 4);
        check_output("ee_cnt", 32'(cnt[1]), 1);
        check_output("ee_cex", 32'(cex[1]), 1);
        check_output("ee_equiv", 32'(equiv[1]), 0);
        check_output("ee_vec_hold", 32'(vec[1]), 1);

        $display("[TB] settle of three cycles");
        apply_stimulus(2, 60, 0, done_edge);
        check_output("s3_done_edge", done_edge, 16);
        check_output("s3_equiv", 32'(equiv[2]), 1);
        check_output("s3_vec_edge3", 32'(vec_trace[3]), 0);
        check_output("s3_vec_edge4", 32'(vec_trace[4]), 1);
        check_output("s3_vec_edge11", 32'(vec_trace[11]), 2);
        check_output("s3_vec_edge12", 32'(vec_trace[12]), 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
